// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state, default fetch queue entry type and saturating counter helper
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;
    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_INST_WIDTH = 32;
    localparam int PERF_WIDTH = 32;
    typedef struct packed {
        logic [DEF_INST_WIDTH-1:0] inst;
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_ADDR_WIDTH-1:0] pcplus4;
    } fetch_entry_t;
    function automatic logic [PERF_WIDTH-1:0] sat_add(input logic [PERF_WIDTH-1:0] a, input logic [PERF_WIDTH-1:0] b);
        logic [PERF_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PERF_WIDTH] ? '1 : s[PERF_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/fetch_unit_q_fifo.sv
// fetch_fifo: circular buffer with enqueue, dequeue and flush; depth must be a power of 2
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enq,
    input  logic          deq,
    input  logic          flush,
    input  entry_t        enq_data,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    // storage is written only by surviving enqueues
    always_ff @(posedge clk)
        if (enq && !flush) mem[wr_ptr] <= enq_data;
    // pointers wrap naturally at DEPTH; flush discards everything
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + CW'(enq) - CW'(deq);
        end
    end
    assign head  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/fetch_unit_q.sv
// fetch_unit_q: sequential PC fetch with one outstanding I-cache request, redirect and a decode queue (option: FETCH_PERF_CNT_EN)
module fetch_unit_q
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int IC_DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int LINE_OFFSET_BITS = 6,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               redirect_valid,
    input  logic [ADDR_WIDTH-1:0]              redirect_target,
    output logic                               ic_req,
    output logic [ADDR_WIDTH-LINE_OFFSET_BITS-1:0] ic_line_addr,
    output logic [LINE_OFFSET_BITS-3:0]        ic_word_select,
    input  logic                               ic_ack,
    input  logic [IC_DATA_WIDTH-1:0]           ic_data_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [INST_WIDTH-1:0]              out_inst,
    output logic [ADDR_WIDTH-1:0]              out_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [PERF_WIDTH-1:0]              perf_fetched,
    output logic [PERF_WIDTH-1:0]              perf_dropped,
    output logic [PERF_WIDTH-1:0]              perf_stall,
`endif
    output logic [ADDR_WIDTH-1:0]              out_pcplus4
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pcplus4;
    } entry_t;
    fetch_state_e state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next, req_pc, target;
    logic [CW-1:0] count, count_next;
    logic enq, deq, full, empty, space, issue, unused;
    entry_t head, enq_data;
    assign unused   = ^{ic_data_out[IC_DATA_WIDTH-1:INST_WIDTH], redirect_target[1:0]};
    assign target   = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    assign deq      = !empty && out_ready;
    assign enq_data = '{inst: ic_data_out[INST_WIDTH-1:0], pc: req_pc, pcplus4: req_pc + ADDR_WIDTH'(4)};
    fetch_fifo #(.DEPTH(QUEUE_DEPTH), .entry_t(entry_t)) u_fifo (
        .clk(clk),
        .reset(reset),
        .enq(enq),
        .deq(deq),
        .flush(redirect_valid),
        .enq_data(enq_data),
        .head(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    // state register, fetch PC and the address of the request in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= issue ? pc_next : req_pc;
        end
    end
    // next state: a new request only while the queue will still have room
    always_comb begin
        count_next = redirect_valid ? '0 : count + CW'(enq) - CW'(deq);
        space      = count_next < CW'(QUEUE_DEPTH);
        state_next = state;
        unique case (state)
            IDLE:    state_next = (redirect_valid || !full || deq) ? REQ : IDLE;
            REQ:     state_next = redirect_valid ? (ic_ack ? REQ : DROP) : (ic_ack && !space) ? IDLE : REQ;
            DROP:    state_next = ic_ack ? REQ : DROP;
            default: state_next = IDLE;
        endcase
        pc_next = redirect_valid ? target : enq ? pc + ADDR_WIDTH'(4) : pc;
        issue   = state_next == REQ && (state != REQ || ic_ack);
    end
    // outputs: a response is kept only in REQ without a concurrent redirect
    always_comb begin
        ic_req      = state != IDLE;
        enq         = state == REQ && ic_ack && !redirect_valid;
        out_valid   = !empty;
        out_inst    = out_valid ? head.inst : '0;
        out_pc      = out_valid ? head.pc : '0;
        out_pcplus4 = out_valid ? head.pcplus4 : '0;
    end
    assign ic_line_addr   = req_pc[ADDR_WIDTH-1:LINE_OFFSET_BITS];
    assign ic_word_select = req_pc[LINE_OFFSET_BITS-1:2];
`ifdef FETCH_PERF_CNT_EN
    logic discard;
    logic [CW-1:0] flushed;
    assign discard = ic_ack && (state == DROP || (state == REQ && redirect_valid));
    assign flushed = redirect_valid ? count - CW'(deq) : '0;
    // saturating event counters; the head leaving on a redirect is not a drop
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, PERF_WIDTH'(enq));
            perf_dropped <= sat_add(perf_dropped, PERF_WIDTH'(flushed) + PERF_WIDTH'(discard));
            perf_stall   <= sat_add(perf_stall, PERF_WIDTH'(state == IDLE && full));
        end
    end
`endif
endmodule
